// File: rtl/datamem_arb_pkg.sv
// Shared types for the data-memory arbiter.
// Round-robin arbitration is enabled by defining DATAMEM_ARB_RR_EN.
package datamem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    DONE
  } arb_state_t;

  localparam logic ARB_ID_A = 1'b0;
  localparam logic ARB_ID_B = 1'b1;

endpackage

// File: rtl/datamem_arb_pick.sv
// Winner picker for the data-memory arbiter.
// DATAMEM_ARB_RR_EN selects round-robin, otherwise A has fixed priority.
module datamem_arb_pick
  import datamem_arb_pkg::*;
(
  input  logic a_req,
  input  logic b_req,
  input  logic last,
  output logic gnt,
  output logic any
);

  assign any = a_req | b_req;

`ifdef DATAMEM_ARB_RR_EN
  // On contention the port that did not win last time goes first
  assign gnt = b_req & (~a_req | (last == ARB_ID_A));
`else
  logic unused_last;
  assign unused_last = last;
  assign gnt = b_req & ~a_req;
`endif

endmodule

// File: rtl/datamem_arbiter.sv
// Two-port arbiter/sequencer for the single-port data memory.
// Define DATAMEM_ARB_RR_EN for round-robin instead of A-first priority.
module datamem_arbiter
  import datamem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_q,
  input  logic              mem_busy
);

  arb_state_t        state;
  arb_state_t        state_nx;
  logic              win;
  logic              win_we;
  logic              last;
  logic              gnt;
  logic              any;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;

  datamem_arb_pick u_pick (
    .a_req (a_req),
    .b_req (b_req),
    .last  (last),
    .gnt   (gnt),
    .any   (any)
  );

  // Strobes depend on state so an async reset kills them at once
  always_comb begin
    state_nx  = state;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    unique case (state)
      IDLE: begin
        if (any) state_nx = ISSUE;
      end
      ISSUE: begin
        mem_addr  = lat_addr;
        mem_wdata = lat_wdata;
        if (!mem_busy) begin
          mem_we   = win_we;
          mem_re   = ~win_we;
          state_nx = win_we ? DONE : CAPTURE;
        end
      end
      CAPTURE: state_nx = DONE;
      DONE:    state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      win       <= ARB_ID_A;
      win_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      last      <= ARB_ID_B;
    end else begin
      state <= state_nx;
      if (state == IDLE && any) begin
        win       <= gnt;
        win_we    <= gnt ? b_we : a_we;
        lat_addr  <= gnt ? b_addr : a_addr;
        lat_wdata <= gnt ? b_wdata : a_wdata;
      end
      if (state == DONE) last <= win;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_ack   <= 1'b0;
      b_ack   <= 1'b0;
      a_rdata <= '0;
      b_rdata <= '0;
    end else begin
      a_ack <= (state_nx == DONE) && (win == ARB_ID_A);
      b_ack <= (state_nx == DONE) && (win == ARB_ID_B);
      if (state == CAPTURE) begin
        if (win == ARB_ID_A) a_rdata <= mem_q;
        else                 b_rdata <= mem_q;
      end
    end
  end

endmodule

// File: tb/tb_datamem_arbiter.sv
// Randomized self-checking bench for datamem_arbiter.
// Reference is a transaction timeline model with its own memory image.
module tb_datamem_arbiter;

`ifdef DATAMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        a_req, a_we, b_req, b_we;
  logic [31:0] a_addr, b_addr, a_wdata, b_wdata;
  logic        a_ack, b_ack;
  logic [31:0] a_rdata, b_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_q;
  logic        mem_we, mem_re, mem_busy;

  always #5 clk = ~clk;

  datamem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .a_req     (a_req),
    .a_we      (a_we),
    .a_addr    (a_addr),
    .a_wdata   (a_wdata),
    .a_ack     (a_ack),
    .a_rdata   (a_rdata),
    .b_req     (b_req),
    .b_we      (b_we),
    .b_addr    (b_addr),
    .b_wdata   (b_wdata),
    .b_ack     (b_ack),
    .b_rdata   (b_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_q     (mem_q),
    .mem_busy  (mem_busy)
  );

  // Memory seen by the DUT; preload port used only during reset
  bit   [31:0] mem [16];
  logic        pre_en = 1'b0;
  logic [3:0]  pre_a = 4'd0;
  logic [31:0] pre_d = 32'd0;

  always @(posedge clk) begin
    if (pre_en) mem[pre_a] <= pre_d;
    else if (mem_we) mem[mem_addr[3:0]] <= mem_wdata;
    if (mem_re) mem_q <= mem[mem_addr[3:0]];
  end

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  int acnt = 0;
  int bcnt = 0;

  bit   [31:0] ref_mem [16];
  logic [31:0] ref_rd [2];
  int          last = 1;
  bit          act = 0;
  bit          iss = 0;
  int          wport = 0;
  bit          wwe = 0;
  logic [31:0] waddr = 0;
  logic [31:0] wwd = 0;
  logic [31:0] cap = 0;
  int          start_c = 0;
  int          ack_c = 0;

  bit          pend [2];
  bit          p_we [2];
  logic [31:0] p_addr [2];
  logic [31:0] p_wd [2];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  task automatic set_req(input int p, input bit we, input int addr,
                         input logic [31:0] wd);
    pend[p]   = 1'b1;
    p_we[p]   = we;
    p_addr[p] = addr;
    p_wd[p]   = wd;
  endtask

  task automatic drive(input bit rnd, input bit hold, input bit busy);
    for (int p = 0; p < 2; p++) begin
      if (!pend[p] && hold)
        set_req(p, 1'b0, p + 1, 32'd0);
      else if (!pend[p] && rnd && $urandom_range(0, 99) < 40)
        set_req(p, 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 15)), $urandom);
    end
    a_req = pend[0]; a_we = p_we[0];
    a_addr = p_addr[0]; a_wdata = p_wd[0];
    b_req = pend[1]; b_we = p_we[1];
    b_addr = p_addr[1]; b_wdata = p_wd[1];
    mem_busy = busy;
  endtask

  // One clock: check outputs mid-cycle, then advance the timeline model
  task automatic step();
    bit stb, ea, eb;
    #3;
    stb = act && !iss && cyc > start_c && !mem_busy;
    ea = act && iss && cyc == ack_c && wport == 0;
    eb = act && iss && cyc == ack_c && wport == 1;
    if ((ea || eb) && !wwe) ref_rd[wport] = cap;
    chk("mem_re", mem_re, stb && !wwe);
    chk("mem_we", mem_we, stb && wwe);
    if (stb) chk("mem_addr", mem_addr, waddr);
    if (stb && wwe) chk("mem_wdata", mem_wdata, wwd);
    chk("a_ack", a_ack, ea);
    chk("b_ack", b_ack, eb);
    chk("a_rdata", a_rdata, ref_rd[0]);
    chk("b_rdata", b_rdata, ref_rd[1]);
    if (a_ack) acnt++;
    if (b_ack) bcnt++;
    if (!act) begin
      if (pend[0] || pend[1]) begin
        if (pend[0] && pend[1]) wport = RR ? (last == 0 ? 1 : 0) : 0;
        else wport = pend[0] ? 0 : 1;
        wwe = p_we[wport];
        waddr = p_addr[wport];
        wwd = p_wd[wport];
        act = 1'b1;
        iss = 1'b0;
        start_c = cyc;
      end
    end else if (stb) begin
      iss = 1'b1;
      ack_c = cyc + (wwe ? 1 : 2);
      if (wwe) ref_mem[waddr[3:0]] = wwd;
      else cap = ref_mem[waddr[3:0]];
    end else if (iss && cyc == ack_c) begin
      last = wport;
      pend[wport] = 1'b0;
      act = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    int n = 0;
    while ((act || pend[0] || pend[1]) && n < 200) begin
      drive(1'b0, 1'b0, 1'b0);
      step();
      n++;
    end
    chk("drain_timeout", 64'(n < 200), 64'd1);
  endtask

  initial begin
    ref_rd[0] = '0;
    ref_rd[1] = '0;
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0; p_we[p] = 1'b0;
      p_addr[p] = '0; p_wd[p] = '0;
    end
    drive(1'b0, 1'b0, 1'b0);
    pre_en = 1'b1; pre_a = 4'd5; pre_d = 32'h1234;
    ref_mem[5] = 32'h1234;
    @(posedge clk);
    #1;
    pre_en = 1'b0;
    #3;
    chk("rst_a_ack", a_ack, 0);
    chk("rst_b_ack", b_ack, 0);
    chk("rst_a_rdata", a_rdata, 0);
    chk("rst_b_rdata", b_rdata, 0);
    chk("rst_mem_re", mem_re, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // A reads address 5
    set_req(0, 1'b0, 5, 32'd0);
    repeat (4) begin drive(1'b0, 1'b0, 1'b0); step(); end
    chk("t1_a_rdata", a_rdata, 32'h1234);
    chk("t1_idle", 64'(act), 64'd0);

    // B writes 0xCAFE to 9 with two busy cycles
    set_req(1, 1'b1, 9, 32'hCAFE);
    drive(1'b0, 1'b0, 1'b0); step();
    drive(1'b0, 1'b0, 1'b1); step();
    drive(1'b0, 1'b0, 1'b1); step();
    drive(1'b0, 1'b0, 1'b0); step();
    drive(1'b0, 1'b0, 1'b0); step();
    chk("t2_b_rdata", b_rdata, 32'd0);
    drain();
    chk("t2_mem9", mem[9], 32'hCAFE);

    // Write via A then read via B
    set_req(0, 1'b1, 3, 32'h55);
    drain();
    set_req(1, 1'b0, 3, 32'd0);
    drain();
    chk("wr_rd_b_rdata", b_rdata, 32'h55);

    // A drops req right after being sampled
    set_req(0, 1'b0, 5, 32'd0);
    drive(1'b0, 1'b0, 1'b0); step();
    pend[0] = 1'b0;
    drain();
    chk("drop_a_rdata", a_rdata, 32'h1234);

    // Both ports read back-to-back for four transactions
    acnt = 0; bcnt = 0;
    repeat (16) begin drive(1'b0, 1'b1, 1'b0); step(); end
    chk("both_a_acks", acnt, RR ? 2 : 4);
    chk("both_b_acks", bcnt, RR ? 2 : 0);
    drain();

    // Reset during the issue cycle of a write
    set_req(0, 1'b1, 7, 32'hDEAD0007);
    drive(1'b0, 1'b0, 1'b0); step();
    drive(1'b0, 1'b0, 1'b0);
    #3;
    chk("rst_we_pre", mem_we, 1);
    reset_n = 1'b0;
    #1;
    chk("rst_we_drop", mem_we, 0);
    @(posedge clk);
    #1;
    cyc++;
    chk("rst_no_ack", a_ack, 0);
    chk("rst_no_write", mem[7], 32'd0);
    reset_n = 1'b1;
    act = 1'b0; last = 1;
    ref_rd[0] = '0; ref_rd[1] = '0;
    drain();
    chk("rst_reserved", mem[7], 32'hDEAD0007);

    // Random traffic with random stalls
    repeat (800) begin
      drive(1'b1, 1'b0, $urandom_range(0, 99) < 30);
      step();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/datamem_arbiter.md
# datamem_arbiter

Two-port arbiter and sequencer in front of the CPU data memory. It lets the CPU load/store unit (port A) and a secondary master such as DMA or debug (port B) share the single-port, one-cycle-read-latency data memory. It honours the memory's `busy` stall, issues exactly one access per granted request, and returns read data with a one-cycle acknowledge pulse.

## Interface
Parameters:
- `ADDR_W`, 32: address width, passed through unmodified.
- `DATA_W`, 32: data width.

Ports:
- `clk`  in  1: system clock, all state on rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `a_req`, `b_req`  in  1: request, held high until the matching ack.
- `a_we`, `b_we`  in  1: 1 = write, 0 = read; stable while req is high.
- `a_addr`, `b_addr`  in  ADDR_W: access address.
- `a_wdata`, `b_wdata`  in  DATA_W: write data.
- `a_ack`, `b_ack`  out  1: one-cycle completion pulse.
- `a_rdata`, `b_rdata`  out  DATA_W: read result, valid in the ack cycle and held until the next ack on that port.
- `mem_addr`  out  ADDR_W, `mem_wdata`  out  DATA_W, `mem_we`  out  1, `mem_re`  out  1: memory command.
- `mem_q`  in  DATA_W: memory read data, valid the cycle after the issue.
- `mem_busy`  in  1: memory cannot accept a command this cycle.

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, DONE.
- IDLE: if any req is high, the picker selects a winner. The arbiter latches the winner id, we, addr and wdata, then moves to ISSUE. With no request, it stays in IDLE.
- ISSUE: the arbiter drives `mem_addr`/`mem_wdata` from the latched values and asserts `mem_re` or `mem_we` only while `mem_busy`=0.
  - `mem_busy`=1: stay in ISSUE with strobes low. The stall can last any number of cycles.
  - `mem_busy`=0 and read: go to CAPTURE.
  - `mem_busy`=0 and write: go to DONE.
- CAPTURE: register `mem_q` into the winner's rdata register, then go to DONE.
- DONE: pulse the winner's ack for one cycle, update the last-grant pointer, and return to IDLE.
- Exactly one memory strobe is issued per transaction. `mem_re` and `mem_we` are never high together.
- A write leaves the port's rdata unchanged.
- Requester drops req before ack (protocol violation): the transaction still completes and the ack still pulses.
- Requester keeps req high after ack: this is treated as a new request in the next IDLE cycle.
- Reset value of every output is 0. Internal reset values: state = IDLE, last-grant pointer = B, rdata registers = 0.
- Reset asserted mid-transaction aborts immediately. `mem_we`/`mem_re` drop asynchronously and no ack is issued.

## Timing
- Let cycle 0 be the IDLE cycle in which req is sampled high.
- Read with no stall: strobe in cycle 1, capture in cycle 2, ack plus rdata in cycle 3.
- Write with no stall: strobe in cycle 1, ack in cycle 2.
- Each cycle of `mem_busy` in ISSUE adds one cycle.
- The arbiter is not pipelined. Peak throughput is one read per 4 cycles or one write per 3 cycles.
- Memory outputs (`mem_addr`, `mem_wdata`, `mem_we`, `mem_re`) are combinational from state and `mem_busy`. Acks and rdata are registered.

## Configuration
- `DATAMEM_ARB_RR_EN` defined: round-robin. When both req are high in IDLE, the port not granted last wins.
- `DATAMEM_ARB_RR_EN` not defined: fixed priority, where A always beats B.
  - B can starve. This is acceptable for CPU-first builds.
  - The last-grant pointer is not implemented.

## Structure
- Package `datamem_arb_pkg` holds:
  - state enum: IDLE, ISSUE, CAPTURE, DONE;
  - requester ids: `ARB_ID_A` = 0, `ARB_ID_B` = 1.
- Sub-module `datamem_arb_pick` is combinational. Inputs: `a_req`, `b_req`, last-grant. Outputs: grant id and any-request. It contains the only `DATAMEM_ARB_RR_EN` conditional.

## Test plan
- After reset: A reads addr 5, memory holds 0x1234 -> `mem_re` in cycle 1, `a_ack`=1 with `a_rdata`=0x1234 in cycle 3, `b_ack` stays 0.
- B writes 0xCAFE to addr 9 while `mem_busy` is high for 2 cycles -> `mem_we` high in only one cycle (cycle 3), `b_ack` in cycle 4, `b_rdata` unchanged.
- A and B both read continuously:
  - with `DATAMEM_ARB_RR_EN`: acks alternate A, B, A, B;
  - without it: only `a_ack` pulses.
- Write-then-read on the same address through different ports: A writes 0x55 to addr 3, then B reads addr 3 -> `b_rdata`=0x55.
- `reset_n` pulled low during ISSUE of a write -> `mem_we` drops in the same cycle, no ack. After release, the FSM is in IDLE and a pending req is re-served from the start.
- A drops req in cycle 1 of a read -> the access still completes and `a_ack` still pulses in cycle 3.
